mii_frame_arbiter: RTL and testbench

//  Round-robin scheduler that shares one 64b/8b MII TX lane among NUM_SRC frame generators.

---
 rtl/mii_frame_arbiter_if.sv | 28 ++
 rtl/mii_frame_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mii_frame_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_frame_arbiter_if.sv
// Source-side request/word bus plus checker-side MII TX outputs of the frame arbiter.
// The master drives source words and watches the grant; the slave is the arbiter.
interface mii_frame_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [NUM_SRC-1:0]            i_req;
  logic [NUM_SRC*DATA_WIDTH-1:0] i_data;
  logic [NUM_SRC*CTRL_WIDTH-1:0] i_ctrl;
  logic [NUM_SRC-1:0]            o_grant;
  logic [DATA_WIDTH-1:0]         o_txd;
  logic [CTRL_WIDTH-1:0]         o_txc;
  logic                          o_busy;
  logic                          o_proto_err;
  logic                          o_timeout;
  logic [15:0]                   o_frame_count;

  modport master (
    output i_req, i_data, i_ctrl,
    input  o_grant, o_txd, o_txc, o_busy, o_proto_err, o_timeout, o_frame_count
  );

  modport slave (
    input  i_req, i_data, i_ctrl,
    output o_grant, o_txd, o_txc, o_busy, o_proto_err, o_timeout, o_frame_count
  );
endinterface

// File: rtl/mii_frame_arbiter.sv
// Round-robin whole-frame arbiter onto one MII TX lane; grant 1 cycle after request, words out 1 cycle after consumption.
// No backpressure: a granted source must supply a word every cycle; IDLE and IPG are inserted between frames.
module mii_frame_arbiter #(
  parameter int         NUM_SRC         = 4,
  parameter int         DATA_WIDTH      = 64,
  parameter int         CTRL_WIDTH      = 8,
  parameter int         IPG_WORDS       = 1,
  parameter int         MAX_FRAME_WORDS = 192,
  parameter logic [7:0] IDLE_CODE       = 8'h07,
  parameter logic [7:0] START_CODE      = 8'hFB,
  parameter logic [7:0] TERM_CODE       = 8'hFD,
  parameter logic [7:0] ERROR_CODE      = 8'hFE
) (
  input logic                clk,
  input logic                i_rst_n,
  mii_frame_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [IW-1:0]         LAST_SRC  = IW'(NUM_SRC - 1);
  localparam logic [CW-1:0]         LAST_WORD = CW'(MAX_FRAME_WORDS - 1);
  localparam logic [3:0]            IPG_LAST  = (IPG_WORDS > 0) ? 4'(IPG_WORDS - 1) : 4'd0;
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] ERR_WORD  = {CTRL_WIDTH{ERROR_CODE}};

  typedef enum logic [1:0] {ARB, XFER, IPG} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]           word_cnt_q, word_cnt_d;
  logic [3:0]              ipg_cnt_q, ipg_cnt_d;
  logic [DATA_WIDTH-1:0]   txd_q, txd_d;
  logic [CTRL_WIDTH-1:0]   txc_q, txc_d;
  logic                    busy_q, busy_d;
  logic                    proto_err_q, proto_err_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic [DATA_WIDTH-1:0]   src_dat [NUM_SRC];
  logic [CTRL_WIDTH-1:0]   src_ctl [NUM_SRC];
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic [CTRL_WIDTH-1:0]   cur_ctl;
  logic                    cur_start;
  logic                    cur_term;
  logic                    win_vld;
  logic [IW-1:0]           win_idx;
  logic [SW-1:0]           cand;
  logic [IW-1:0]           next_ptr;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src_dat[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign src_ctl[k] = bus.i_ctrl[k*CTRL_WIDTH +: CTRL_WIDTH];
  end

  assign cur_dat   = src_dat[gidx_q];
  assign cur_ctl   = src_ctl[gidx_q];
  assign cur_start = cur_ctl[0] && (cur_dat[7:0] == START_CODE);
  assign next_ptr  = (gidx_q == LAST_SRC) ? '0 : gidx_q + IW'(1);

  always_comb begin
    cur_term = 1'b0;
    for (int j = 0; j < CTRL_WIDTH; j++) begin
      if (cur_ctl[j] && (cur_dat[j*8 +: 8] == TERM_CODE)) cur_term = 1'b1;
    end
  end

  // Walk offsets from highest to lowest so the candidate nearest rr_ptr is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + SW'(i);
      if (cand >= SW'(NUM_SRC)) cand = cand - SW'(NUM_SRC);
      if (bus.i_req[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    word_cnt_d  = word_cnt_q;
    ipg_cnt_d   = ipg_cnt_q;
    txd_d       = IDLE_WORD;
    txc_d       = '1;
    proto_err_d = 1'b0;
    timeout_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ARB: begin
        if (win_vld) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          word_cnt_d       = '0;
          state_d          = XFER;
        end
      end
      XFER: begin
        txd_d      = cur_dat;
        txc_d      = cur_ctl;
        word_cnt_d = word_cnt_q + CW'(1);
        if ((word_cnt_q == '0) && !cur_start) proto_err_d = 1'b1;
        // TERM is checked first so a frame ending exactly at the limit still completes normally.
        if (cur_term || (word_cnt_q == LAST_WORD)) begin
          grant_d   = '0;
          rr_ptr_d  = next_ptr;
          ipg_cnt_d = '0;
          state_d   = (IPG_WORDS == 0) ? ARB : IPG;
          if (cur_term) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            txd_d     = ERR_WORD;
            txc_d     = '1;
            timeout_d = 1'b1;
          end
        end
      end
      IPG: begin
        ipg_cnt_d = ipg_cnt_q + 4'd1;
        if (ipg_cnt_q == IPG_LAST) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    busy_d = (state_d == XFER);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      ipg_cnt_q   <= '0;
      txd_q       <= IDLE_WORD;
      txc_q       <= '1;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      ipg_cnt_q   <= ipg_cnt_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_txd         = txd_q;
  assign bus.o_txc         = txc_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_proto_err   = proto_err_q;
  assign bus.o_timeout     = timeout_q;
  assign bus.o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_mii_frame_arbiter.sv
// Directed bench for mii_frame_arbiter: per-source word tables stand in for frame generators.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mii_frame_arbiter;
  localparam int NS   = 4;
  localparam int DW   = 64;
  localparam int CWD  = 8;
  localparam int MAXW = 192;
  localparam int DEP  = 200;
  localparam logic [63:0] IDLE_W = {8{8'h07}};
  localparam logic [63:0] ERR_W  = {8{8'hFE}};
  localparam logic [63:0] TERM_W = {{7{8'h07}}, 8'hFD};

  logic clk;
  logic i_rst_n;

  mii_frame_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CTRL_WIDTH(CWD)) bus ();

  mii_frame_arbiter #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .CTRL_WIDTH(CWD),
    .IPG_WORDS(1), .MAX_FRAME_WORDS(MAXW)
  ) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] fdat [NS][DEP];
  logic [7:0]  fctl [NS][DEP];
  int          ptr  [NS];
  int          flen [NS];
  int          reps [NS];
  logic [3:0]  order   [5];
  logic [3:0]  exp_ord [5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
  int          n_ord;
  logic [3:0]  prev_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      bus.i_data[k*DW +: DW]   = fdat[k][ptr[k]];
      bus.i_ctrl[k*CWD +: CWD] = fctl[k][ptr[k]];
      bus.i_req[k]             = (reps[k] > 0);
    end
  endtask

  // One clock: every source granted across the edge has its word consumed and presents the next.
  task automatic tick();
    logic [NS-1:0] g;
    g = bus.o_grant;
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++) begin
      if (g[k]) begin
        ptr[k]++;
        if (ptr[k] >= flen[k]) begin
          ptr[k] = 0;
          if (reps[k] > 0) reps[k]--;
        end
      end
    end
    drive();
  endtask

  task automatic build_frame(input int k, input int len);
    for (int w = 0; w < DEP; w++) begin
      fdat[k][w] = {8'(k), 24'hD47A00, 32'(w)};
      fctl[k][w] = 8'h00;
    end
    fdat[k][0]     = {8'(8'hA0 + k), 48'h5A5A5A5A5A5A, 8'hFB};
    fctl[k][0]     = 8'h01;
    fdat[k][len-1] = TERM_W;
    fctl[k][len-1] = 8'hFF;
    flen[k] = len;
    ptr[k]  = 0;
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string tag);
    for (int c = 0; c < 12 && bus.o_grant == '0; c++) tick();
    chk(tag, bus.o_grant, exp);
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < NS; k++) begin
      build_frame(k, 3);
      reps[k] = 0;
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    clear_srcs();
    drive();
    #12;
    chk("rst_grant", bus.o_grant, 4'h0);
    chk("rst_txd", bus.o_txd, IDLE_W);
    chk("rst_txc", bus.o_txc, 8'hFF);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_count", bus.o_frame_count, 16'd0);
    chk("rst_perr", bus.o_proto_err, 1'b0);
    chk("rst_tout", bus.o_timeout, 1'b0);
    @(posedge clk);
    #1 i_rst_n = 1'b1;

    // Single 9-word frame from source 1.
    build_frame(1, 9);
    reps[1] = 1;
    drive();
    wait_grant(4'b0010, "t1_grant");
    chk("t1_busy", bus.o_busy, 1'b1);
    chk("t1_arb_idle", bus.o_txd, IDLE_W);
    for (int w = 0; w < 9; w++) begin
      tick();
      chk("t1_txd", bus.o_txd, fdat[1][w]);
      chk("t1_txc", bus.o_txc, fctl[1][w]);
      chk("t1_grant_hold", bus.o_grant, (w < 8) ? 4'b0010 : 4'b0000);
      chk("t1_perr", bus.o_proto_err, 1'b0);
    end
    chk("t1_count", bus.o_frame_count, 16'd1);
    chk("t1_busy_end", bus.o_busy, 1'b0);
    tick();
    chk("t1_ipg0", bus.o_txd, IDLE_W);
    chk("t1_ipg0_c", bus.o_txc, 8'hFF);
    tick();
    chk("t1_ipg1", bus.o_txd, IDLE_W);
    chk("t1_ipg1_g", bus.o_grant, 4'h0);

    // All four requesting from rr_ptr=0; source 0 wants two frames.
    i_rst_n = 1'b0;
    #1;
    clear_srcs();
    reps[0] = 2; reps[1] = 1; reps[2] = 1; reps[3] = 1;
    drive();
    @(posedge clk);
    #1 i_rst_n = 1'b1;
    n_ord  = 0;
    prev_g = 4'h0;
    for (int i = 0; i < 5; i++) order[i] = 4'h0;
    for (int c = 0; c < 80 && n_ord < 5; c++) begin
      tick();
      if (bus.o_grant != 4'h0 && prev_g == 4'h0) begin
        order[n_ord] = bus.o_grant;
        n_ord++;
      end
      prev_g = bus.o_grant;
    end
    for (int i = 0; i < 5; i++) chk("t2_order", order[i], exp_ord[i]);
    for (int c = 0; c < 10; c++) tick();
    chk("t2_count", bus.o_frame_count, 16'd5);
    chk("t2_idle_grant", bus.o_grant, 4'h0);

    // Source 2 never terminates: watchdog at word 192.
    build_frame(2, DEP);
    fdat[2][DEP-1] = 64'h0;
    fctl[2][DEP-1] = 8'h00;
    reps[2] = 1;
    drive();
    wait_grant(4'b0100, "t3_grant");
    for (int w = 0; w < MAXW - 1; w++) begin
      tick();
      chk("t3_txd", bus.o_txd, fdat[2][w]);
    end
    chk("t3_no_tout_early", bus.o_timeout, 1'b0);
    tick();
    chk("t3_err_txd", bus.o_txd, ERR_W);
    chk("t3_err_txc", bus.o_txc, 8'hFF);
    chk("t3_tout", bus.o_timeout, 1'b1);
    chk("t3_grant", bus.o_grant, 4'h0);
    chk("t3_count", bus.o_frame_count, 16'd5);
    chk("t3_busy", bus.o_busy, 1'b0);
    reps[2] = 0;
    ptr[2]  = 0;
    drive();
    tick();
    chk("t3_tout_pulse", bus.o_timeout, 1'b0);

    // Source 3 opens with a non-START word.
    fdat[3][0] = 64'h0123456789ABCD55;
    fctl[3][0] = 8'h00;
    fdat[3][1] = TERM_W;
    fctl[3][1] = 8'hFF;
    flen[3] = 2;
    ptr[3]  = 0;
    reps[3] = 1;
    drive();
    wait_grant(4'b1000, "t4_grant");
    tick();
    chk("t4_txd", bus.o_txd, 64'h0123456789ABCD55);
    chk("t4_txc", bus.o_txc, 8'h00);
    chk("t4_perr", bus.o_proto_err, 1'b1);
    tick();
    chk("t4_perr_pulse", bus.o_proto_err, 1'b0);
    chk("t4_term", bus.o_txd, TERM_W);
    chk("t4_count", bus.o_frame_count, 16'd6);

    // Move rr_ptr to 3, then reset in the middle of a source 3 frame.
    build_frame(2, 3);
    reps[2] = 1;
    drive();
    wait_grant(4'b0100, "t5_pre_grant");
    for (int c = 0; c < 3; c++) tick();
    chk("t5_pre_count", bus.o_frame_count, 16'd7);
    build_frame(3, 10);
    reps[3] = 1;
    drive();
    wait_grant(4'b1000, "t5_grant");
    for (int c = 0; c < 4; c++) tick();
    chk("t5_word3", bus.o_txd, fdat[3][3]);
    #1 i_rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", bus.o_grant, 4'h0);
    chk("t5_rst_txd", bus.o_txd, IDLE_W);
    chk("t5_rst_txc", bus.o_txc, 8'hFF);
    chk("t5_rst_busy", bus.o_busy, 1'b0);
    chk("t5_rst_count", bus.o_frame_count, 16'd0);
    clear_srcs();
    build_frame(1, MAXW);
    fdat[1][MAXW-1] = 64'h1111_FD22_3333_4444;
    fctl[1][MAXW-1] = 8'h20;
    build_frame(3, 10);
    reps[1] = 1;
    reps[3] = 1;
    drive();
    @(posedge clk);
    #1 i_rst_n = 1'b1;
    wait_grant(4'b0010, "t5_rr_from_0");

    // TERM in lane 5 on the very word the watchdog would fire.
    for (int w = 0; w < MAXW; w++) begin
      tick();
      chk("t6_txd", bus.o_txd, fdat[1][w]);
    end
    chk("t6_txc", bus.o_txc, 8'h20);
    chk("t6_no_tout", bus.o_timeout, 1'b0);
    chk("t6_grant", bus.o_grant, 4'h0);
    chk("t6_count", bus.o_frame_count, 16'd1);
    wait_grant(4'b1000, "t6_next_grant");
    for (int c = 0; c < 12; c++) tick();
    chk("t6_count2", bus.o_frame_count, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
